// File: rtl/setup_hold_monitor.sv
// Setup/hold timing monitor: synchronizes a data line and a target clock, measures
// the data-to-clock setup margin and flags setup and hold-window violations.
module setup_hold_monitor #(
   parameter int unsigned SETUP_CYC = 4,
   parameter int unsigned HOLD_CYC  = 2,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d_in,
   input  logic             tclk_in,
   input  logic             clr,
   output logic             setup_viol,
   output logic             hold_viol,
   output logic [CNT_W-1:0] setup_cnt,
   output logic [CNT_W-1:0] hold_cnt,
   output logic [CNT_W-1:0] last_margin,
   output logic             margin_valid
);

   localparam int unsigned KW = $clog2(HOLD_CYC + 2);
   localparam logic [CNT_W-1:0] MAX = '1;

   typedef enum logic {IDLE, HOLD_WIN} state_t;

   state_t           state_q;
   logic [KW-1:0]    k_q;
   logic             d_s1_q, d_s2_q, d_prev_q;
   logic             t_s1_q, t_s2_q, t_prev_q;
   logic [CNT_W-1:0] mcnt_q, mcnt_d;
   logic [CNT_W-1:0] setup_cnt_q, setup_cnt_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0] last_margin_q, last_margin_d;
   logic             margin_valid_q, margin_valid_d;
   logic             setup_viol_q, hold_viol_q;

   logic             d_edge, t_rise, setup_det, hold_det;
   logic [CNT_W-1:0] margin;
   logic [KW-1:0]    k_cur;

   always_comb begin
      d_edge    = d_s2_q ^ d_prev_q;
      t_rise    = t_s2_q & ~t_prev_q;
      margin    = d_edge ? '0 : mcnt_q;
      setup_det = t_rise && (margin < CNT_W'(SETUP_CYC));
      // a data edge coincident with a target rise is a setup event only
      hold_det  = (state_q == HOLD_WIN) && !t_rise && d_edge;
      k_cur     = k_q + KW'(1);

      mcnt_d = mcnt_q;
      if (d_edge)
         mcnt_d = CNT_W'(1);
      else if (mcnt_q != MAX)
         mcnt_d = mcnt_q + CNT_W'(1);

      setup_cnt_d    = setup_cnt_q;
      hold_cnt_d     = hold_cnt_q;
      last_margin_d  = last_margin_q;
      margin_valid_d = margin_valid_q;
      if (clr) begin
         setup_cnt_d    = '0;
         hold_cnt_d     = '0;
         last_margin_d  = '0;
         margin_valid_d = 1'b0;
      end else begin
         if (setup_det && setup_cnt_q != MAX)
            setup_cnt_d = setup_cnt_q + CNT_W'(1);
         if (hold_det && hold_cnt_q != MAX)
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
         if (t_rise) begin
            last_margin_d  = margin;
            margin_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_s1_q         <= 1'b0;
         d_s2_q         <= 1'b0;
         d_prev_q       <= 1'b0;
         t_s1_q         <= 1'b0;
         t_s2_q         <= 1'b0;
         t_prev_q       <= 1'b0;
         mcnt_q         <= MAX;
         setup_cnt_q    <= '0;
         hold_cnt_q     <= '0;
         last_margin_q  <= '0;
         margin_valid_q <= 1'b0;
      end else begin
         d_s1_q         <= d_in;
         d_s2_q         <= d_s1_q;
         d_prev_q       <= d_s2_q;
         t_s1_q         <= tclk_in;
         t_s2_q         <= t_s1_q;
         t_prev_q       <= t_s2_q;
         mcnt_q         <= mcnt_d;
         setup_cnt_q    <= setup_cnt_d;
         hold_cnt_q     <= hold_cnt_d;
         last_margin_q  <= last_margin_d;
         margin_valid_q <= margin_valid_d;
      end
   end

   // hold-window FSM with registered violation pulses; k_q is the offset of the previous cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         k_q          <= '0;
         setup_viol_q <= 1'b0;
         hold_viol_q  <= 1'b0;
      end else begin
         setup_viol_q <= setup_det;
         hold_viol_q  <= hold_det;
         if (t_rise) begin
            state_q <= HOLD_WIN;
            k_q     <= '0;
         end else if (state_q == HOLD_WIN) begin
            if (d_edge || k_cur >= KW'(HOLD_CYC)) begin
               state_q <= IDLE;
               k_q     <= '0;
            end else begin
               k_q <= k_cur;
            end
         end
      end
   end

   assign setup_viol   = setup_viol_q;
   assign hold_viol    = hold_viol_q;
   assign setup_cnt    = setup_cnt_q;
   assign hold_cnt     = hold_cnt_q;
   assign last_margin  = last_margin_q;
   assign margin_valid = margin_valid_q;

endmodule

// File: tb/tb_setup_hold_monitor.sv
// Directed bench for setup_hold_monitor with default parameters (4/2/8).
module tb_setup_hold_monitor;

   logic       clk = 1'b0;
   logic       rst, d_in, tclk_in, clr;
   logic       setup_viol, hold_viol, margin_valid;
   logic [7:0] setup_cnt, hold_cnt, last_margin;

   int checks = 0;
   int errors = 0;
   int sv_pulses = 0;
   int hv_pulses = 0;
   int sv_base, hv_base;

   setup_hold_monitor #(.SETUP_CYC(4), .HOLD_CYC(2), .CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .d_in         (d_in),
      .tclk_in      (tclk_in),
      .clr          (clr),
      .setup_viol   (setup_viol),
      .hold_viol    (hold_viol),
      .setup_cnt    (setup_cnt),
      .hold_cnt     (hold_cnt),
      .last_margin  (last_margin),
      .margin_valid (margin_valid)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (setup_viol) sv_pulses++;
      if (hold_viol)  hv_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic mark();
      sv_base = sv_pulses;
      hv_base = hv_pulses;
   endtask

   // toggle d_in, then raise tclk_in dly cycles later
   task automatic setup_case(input int dly);
      mark();
      @(negedge clk) d_in = ~d_in;
      repeat (dly) @(negedge clk);
      tclk_in = 1'b1;
      repeat (6) @(negedge clk);
      tclk_in = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   // raise tclk_in, then toggle d_in aft cycles later
   task automatic hold_case(input int aft);
      mark();
      @(negedge clk) tclk_in = 1'b1;
      repeat (aft) @(negedge clk);
      d_in = ~d_in;
      repeat (6) @(negedge clk);
      tclk_in = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; d_in = 1'b0; tclk_in = 1'b0; clr = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_setup_viol", setup_viol, 0);
      check("rst_hold_viol", hold_viol, 0);
      check("rst_setup_cnt", setup_cnt, 0);
      check("rst_hold_cnt", hold_cnt, 0);
      check("rst_margin", last_margin, 0);
      check("rst_valid", margin_valid, 0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      setup_case(10);
      check("m10_pulses", sv_pulses - sv_base, 0);
      check("m10_margin", last_margin, 10);
      check("m10_valid", margin_valid, 1);

      setup_case(2);
      check("m2_pulses", sv_pulses - sv_base, 1);
      check("m2_cnt", setup_cnt, 1);
      check("m2_margin", last_margin, 2);

      setup_case(4);
      check("m4_pulses", sv_pulses - sv_base, 0);
      check("m4_margin", last_margin, 4);

      setup_case(3);
      check("m3_pulses", sv_pulses - sv_base, 1);
      check("m3_cnt", setup_cnt, 2);

      setup_case(0);
      check("m0_pulses", sv_pulses - sv_base, 1);
      check("m0_cnt", setup_cnt, 3);
      check("m0_margin", last_margin, 0);
      check("m0_hold_cnt", hold_cnt, 0);
      check("m0_hold_pulses", hv_pulses - hv_base, 0);

      hold_case(1);
      check("h1_pulses", hv_pulses - hv_base, 1);
      check("h1_cnt", hold_cnt, 1);
      check("h1_setup_pulses", sv_pulses - sv_base, 0);

      hold_case(2);
      check("h2_pulses", hv_pulses - hv_base, 1);
      check("h2_cnt", hold_cnt, 2);

      hold_case(3);
      check("h3_pulses", hv_pulses - hv_base, 0);
      check("h3_cnt", hold_cnt, 2);

      // second target rise two cycles into a window restarts it
      mark();
      @(negedge clk) tclk_in = 1'b1;
      @(negedge clk) tclk_in = 1'b0;
      @(negedge clk) tclk_in = 1'b1;
      repeat (2) @(negedge clk);
      d_in = ~d_in;
      repeat (6) @(negedge clk);
      tclk_in = 1'b0;
      repeat (6) @(negedge clk);
      check("restart_pulses", hv_pulses - hv_base, 1);
      check("restart_cnt", hold_cnt, 3);
      check("restart_setup_cnt", setup_cnt, 3);

      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      check("clr_setup_cnt", setup_cnt, 0);
      check("clr_hold_cnt", hold_cnt, 0);
      check("clr_margin", last_margin, 0);
      check("clr_valid", margin_valid, 0);

      // reset asserted at window offset k=1
      mark();
      @(negedge clk) tclk_in = 1'b1;
      repeat (3) @(negedge clk);
      check("mw_valid_pre", margin_valid, 1);
      rst = 1'b0; tclk_in = 1'b0;
      #1;
      check("mw_async_valid", margin_valid, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk) d_in = ~d_in;
      repeat (8) @(negedge clk);
      check("mw_hold_pulses", hv_pulses - hv_base, 0);
      check("mw_hold_cnt", hold_cnt, 0);
      check("mw_setup_cnt", setup_cnt, 0);
      check("mw_valid", margin_valid, 0);
      check("mw_margin", last_margin, 0);

      // target clock held high through reset release
      mark();
      @(negedge clk) begin tclk_in = 1'b1; rst = 1'b0; end
      @(negedge clk) rst = 1'b1;
      repeat (6) @(negedge clk);
      check("hi_rel_valid", margin_valid, 1);
      check("hi_rel_margin", last_margin, 255);
      check("hi_rel_pulses", sv_pulses - sv_base, 0);
      tclk_in = 1'b0;
      repeat (6) @(negedge clk);

      mark();
      for (int i = 0; i < 260; i++) begin
         @(negedge clk) begin d_in = ~d_in; tclk_in = 1'b1; end
         @(negedge clk) tclk_in = 1'b0;
         @(negedge clk);
      end
      repeat (6) @(negedge clk);
      check("sat_pulses", sv_pulses - sv_base, 260);
      check("sat_cnt", setup_cnt, 255);
      check("sat_hold_cnt", hold_cnt, 0);

      // clr lands on the same edge as a violation and a margin load
      mark();
      @(negedge clk) begin d_in = ~d_in; tclk_in = 1'b1; end
      @(negedge clk) tclk_in = 1'b0;
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      repeat (3) @(negedge clk);
      check("clrv_pulses", sv_pulses - sv_base, 1);
      check("clrv_cnt", setup_cnt, 0);
      check("clrv_valid", margin_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
